lcd_read_fsm: RTL and testbench

- Read-side engine for the 4-bit character-LCD bus, the counterpart of the write and initialization path.
- Performs one HD44780-style 8-bit read as two nibble strobes with LCD_RW=1, high nibble first.
  - LCD_RS=0: busy flag and address counter.
  - LCD_RS=1: DDRAM/CGRAM data.
- Used by the command sequencer to poll the busy flag instead of waiting on fixed delays. It never drives the data lines.

---
 rtl/lcd_pkg.sv | 26 ++
 rtl/lcd_read_fsm_if.sv | 29 ++
 rtl/lcd_delay_counter.sv | 26 ++
 rtl/lcd_read_fsm.sv | 130 +++++++++++++
 tb/tb_lcd_read_fsm.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD read and write/initialization paths.
// Holds the read FSM state encoding, register-select codes and default bus timing.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_E1    = 3'd2,
    ST_HOLD1 = 3'd3,
    ST_GAP   = 3'd4,
    ST_E2    = 3'd5,
    ST_HOLD2 = 3'd6,
    ST_DONE  = 3'd7
  } lcd_rd_state_e;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  // Cycle counts at a 50 MHz clock.
  localparam int LCD_SETUP_CYC  = 2;
  localparam int LCD_E_HIGH_CYC = 12;
  localparam int LCD_HOLD_CYC   = 1;
  localparam int LCD_GAP_CYC    = 50;
  localparam int LCD_CNT_W      = 8;

endpackage

// File: rtl/lcd_read_fsm_if.sv
// Request/result handshake plus LCD pin group for the read engine.
// The requester and the pad side drive req/req_rs/SF_D_in; the engine drives everything else.
interface lcd_read_fsm_if;
  import lcd_pkg::*;

  logic       req;
  logic       req_rs;
  logic       ready;
  logic       valid;
  logic [7:0] data_out;
  logic       busy_flag;
  logic [6:0] addr;
  logic       bus_busy;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [3:0] SF_D_in;

  modport master (
    output req, req_rs, SF_D_in,
    input  ready, valid, data_out, busy_flag, addr, bus_busy, LCD_E, LCD_RS, LCD_RW
  );

  modport slave (
    input  req, req_rs, SF_D_in,
    output ready, valid, data_out, busy_flag, addr, bus_busy, LCD_E, LCD_RS, LCD_RW
  );

endinterface

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter used to time LCD bus phases; done is high while value is zero.
// Load wins over counting; the counter parks at zero until the next load.
module lcd_delay_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             done
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign done = (value == '0);

endmodule

// File: rtl/lcd_read_fsm.sv
// Two-nibble HD44780 read (high nibble first); result valid SETUP+2*E_HIGH+2*HOLD+GAP+1 cycles after accept.
// Requests are taken only in IDLE (ready=1); anything arriving while busy is dropped, not queued.
module lcd_read_fsm
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC  = LCD_SETUP_CYC,
  parameter int E_HIGH_CYC = LCD_E_HIGH_CYC,
  parameter int HOLD_CYC   = LCD_HOLD_CYC,
  parameter int GAP_CYC    = LCD_GAP_CYC,
  parameter int CNT_W      = LCD_CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  lcd_read_fsm_if.slave bus
);

  lcd_rd_state_e    state;
  lcd_rd_state_e    state_nxt;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_done;

  logic             lcd_e;
  logic             lcd_rs;
  logic             lcd_rw;
  logic             bus_busy;
  logic             valid;
  logic [7:0]       data_out;
  logic [3:0]       nib_hi;
  logic [3:0]       nib_lo;

  // Counter is loaded with (length-1) on entry so each timed state lasts exactly its length.
  function automatic logic [CNT_W-1:0] phase_len(input lcd_rd_state_e s);
    logic [CNT_W-1:0] len;
    len = '0;
    case (s)
      ST_SETUP:        len = CNT_W'(SETUP_CYC - 1);
      ST_E1, ST_E2:    len = CNT_W'(E_HIGH_CYC - 1);
      ST_HOLD1,
      ST_HOLD2:        len = CNT_W'(HOLD_CYC - 1);
      ST_GAP:          len = CNT_W'(GAP_CYC - 1);
      default:         len = '0;
    endcase
    return len;
  endfunction

  function automatic logic owns_bus(input lcd_rd_state_e s);
    return s inside {ST_SETUP, ST_E1, ST_HOLD1, ST_GAP, ST_E2, ST_HOLD2};
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.req)  state_nxt = ST_SETUP;
      ST_SETUP: if (cnt_done) state_nxt = ST_E1;
      ST_E1:    if (cnt_done) state_nxt = ST_HOLD1;
      ST_HOLD1: if (cnt_done) state_nxt = ST_GAP;
      ST_GAP:   if (cnt_done) state_nxt = ST_E2;
      ST_E2:    if (cnt_done) state_nxt = ST_HOLD2;
      ST_HOLD2: if (cnt_done) state_nxt = ST_DONE;
      ST_DONE:                state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Every transition enters a different state, so a state change is the entry event.
  assign cnt_load     = (state_nxt != state);
  assign cnt_load_val = phase_len(state_nxt);

  lcd_delay_counter #(
    .CNT_W (CNT_W)
  ) u_delay (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .value    (cnt_value),
    .done     (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      lcd_e    <= 1'b0;
      lcd_rs   <= RS_CMD;
      lcd_rw   <= 1'b0;
      bus_busy <= 1'b0;
      valid    <= 1'b0;
      data_out <= 8'h00;
      nib_hi   <= 4'h0;
      nib_lo   <= 4'h0;
    end else begin
      state    <= state_nxt;
      valid    <= 1'b0;
      lcd_e    <= (state_nxt == ST_E1) || (state_nxt == ST_E2);
      lcd_rw   <= owns_bus(state_nxt);
      bus_busy <= owns_bus(state_nxt);

      // RS only moves on accept and on entry to DONE, both with E low.
      if (state == ST_IDLE && bus.req) begin
        lcd_rs <= bus.req_rs;
      end else if (state_nxt == ST_DONE) begin
        lcd_rs <= RS_CMD;
      end

      if (state == ST_E1 && cnt_done) begin
        nib_hi <= bus.SF_D_in;
      end
      if (state == ST_E2 && cnt_done) begin
        nib_lo <= bus.SF_D_in;
      end
      if (state == ST_HOLD2 && cnt_done) begin
        data_out <= {nib_hi, nib_lo};
        valid    <= 1'b1;
      end
    end
  end

  assign bus.ready     = (state == ST_IDLE);
  assign bus.valid     = valid;
  assign bus.data_out  = data_out;
  assign bus.busy_flag = data_out[7];
  assign bus.addr      = data_out[6:0];
  assign bus.bus_busy  = bus_busy;
  assign bus.LCD_E     = lcd_e;
  assign bus.LCD_RS    = lcd_rs;
  assign bus.LCD_RW    = lcd_rw;

endmodule

// File: tb/tb_lcd_read_fsm.sv
// Directed bench for lcd_read_fsm: default-timing instance plus a short-timing instance.
module tb_lcd_read_fsm;
  import lcd_pkg::*;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic       rs_in = 1'b0;
  logic [3:0] sf    = 4'h0;
  bit         sel   = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lcd_read_fsm_if ifa ();
  lcd_read_fsm_if ifb ();

  assign ifa.req     = req_a;
  assign ifa.req_rs  = rs_in;
  assign ifa.SF_D_in = sf;
  assign ifb.req     = req_b;
  assign ifb.req_rs  = rs_in;
  assign ifb.SF_D_in = sf;

  lcd_read_fsm dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  lcd_read_fsm #(
    .SETUP_CYC  (1),
    .E_HIGH_CYC (3),
    .HOLD_CYC   (1),
    .GAP_CYC    (4),
    .CNT_W      (8)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  logic       o_e, o_rs, o_rw, o_bb, o_vld, o_rdy, o_bf;
  logic [7:0] o_dat;
  logic [6:0] o_addr;

  assign o_e    = sel ? ifb.LCD_E     : ifa.LCD_E;
  assign o_rs   = sel ? ifb.LCD_RS    : ifa.LCD_RS;
  assign o_rw   = sel ? ifb.LCD_RW    : ifa.LCD_RW;
  assign o_bb   = sel ? ifb.bus_busy  : ifa.bus_busy;
  assign o_vld  = sel ? ifb.valid     : ifa.valid;
  assign o_rdy  = sel ? ifb.ready     : ifa.ready;
  assign o_bf   = sel ? ifb.busy_flag : ifa.busy_flag;
  assign o_dat  = sel ? ifb.data_out  : ifa.data_out;
  assign o_addr = sel ? ifb.addr      : ifa.addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One read on the selected instance; sf switches to the low nibble when the first E pulse ends.
  task automatic do_read(input string tag, input logic rs, input logic [3:0] hi, input logic [3:0] lo,
                         input int exp_lat, input int exp_eh, input bit jitter);
    int   lat     = 0;
    int   np      = 0;
    int   cur     = 0;
    int   bad     = 0;
    int   rdy_bad = 0;
    int   pw [2];
    logic pe      = 1'b0;
    logic r;
    pw[0] = 0;
    pw[1] = 0;
    rs_in = rs;
    sf    = hi;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    tick();
    req_a = 1'b0;
    req_b = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (o_vld === 1'b1) begin
        lat = k;
        break;
      end
      if (o_bb !== 1'b1 || o_rw !== 1'b1 || o_rs !== rs) bad++;
      if (o_rdy !== 1'b0) rdy_bad++;
      if (o_e === 1'b1) begin
        cur++;
      end else if (pe === 1'b1) begin
        if (np < 2) pw[np] = cur;
        np++;
        cur = 0;
        sf  = lo;
      end
      pe = o_e;
      r  = jitter && (k >= 20) && (k <= 75) && (k % 2 == 1);
      if (sel) req_b = r; else req_a = r;
      tick();
    end
    req_a = 1'b0;
    req_b = 1'b0;
    chk({tag, "_latency"},   lat, exp_lat);
    chk({tag, "_e_pulses"},  np, 2);
    chk({tag, "_e1_width"},  pw[0], exp_eh);
    chk({tag, "_e2_width"},  pw[1], exp_eh);
    chk({tag, "_rs_rw_bb"},  bad, 0);
    chk({tag, "_ready_low"}, rdy_bad, 0);
    chk({tag, "_data"},      o_dat, {24'h0, hi, lo});
    chk({tag, "_busy_flag"}, o_bf, hi[3]);
    chk({tag, "_addr"},      o_addr, {25'h0, hi[2:0], lo});
    chk({tag, "_done_bb"},   o_bb, 1'b0);
    chk({tag, "_done_rw"},   o_rw, 1'b0);
    chk({tag, "_done_rs"},   o_rs, 1'b0);
    tick();
    chk({tag, "_valid_1cyc"}, o_vld, 1'b0);
    chk({tag, "_ready_back"}, o_rdy, 1'b1);
  endtask

  initial begin : stim
    int   extra;
    int   nv;
    int   vc [3];
    int   bad;
    logic prs, prw, pe;

    // Reset state
    sel   = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    chk("rst_e",     o_e, 1'b0);
    chk("rst_rs",    o_rs, 1'b0);
    chk("rst_rw",    o_rw, 1'b0);
    chk("rst_bb",    o_bb, 1'b0);
    chk("rst_valid", o_vld, 1'b0);
    chk("rst_data",  o_dat, 8'h00);
    reset = 1'b1;
    tick();
    chk("rst_ready", o_rdy, 1'b1);

    // Busy-flag read and data read
    do_read("bf_read",   RS_CMD,  4'h8, 4'h5, 79, 12, 1'b0);
    do_read("data_read", RS_DATA, 4'h4, 4'h1, 79, 12, 1'b0);

    // req toggling during GAP/E2 must be ignored
    do_read("glitch", RS_CMD, 4'h3, 4'hC, 79, 12, 1'b1);
    extra = 0;
    repeat (20) begin
      tick();
      if (o_vld === 1'b1) extra++;
    end
    chk("glitch_extra_valid", extra, 0);

    // Back-to-back reads with req held high
    rs_in = RS_DATA;
    sf    = 4'hA;
    nv    = 0;
    bad   = 0;
    vc[0] = 0; vc[1] = 0; vc[2] = 0;
    prs   = o_rs;
    prw   = o_rw;
    pe    = o_e;
    req_a = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if ((o_rs !== prs || o_rw !== prw) && (o_e !== 1'b0 || pe !== 1'b0)) bad++;
      prs = o_rs;
      prw = o_rw;
      pe  = o_e;
      if (o_vld === 1'b1) begin
        if (nv < 3) vc[nv] = k;
        nv++;
        if (nv == 3) begin
          req_a = 1'b0;
          break;
        end
      end
    end
    req_a = 1'b0;
    chk("b2b_count",     nv, 3);
    chk("b2b_first",     vc[0], 79);
    chk("b2b_period_1",  vc[1] - vc[0], 80);
    chk("b2b_period_2",  vc[2] - vc[1], 80);
    chk("b2b_rsrw_vs_e", bad, 0);
    chk("b2b_data",      o_dat, 8'hAA);
    tick();
    tick();

    // Reset asserted mid-E1 aborts the read
    rs_in = RS_CMD;
    sf    = 4'hF;
    req_a = 1'b1;
    tick();
    req_a = 1'b0;
    repeat (7) tick();
    chk("abort_in_e1", o_e, 1'b1);
    reset = 1'b0;
    tick();
    chk("abort_e",     o_e, 1'b0);
    chk("abort_rw",    o_rw, 1'b0);
    chk("abort_rs",    o_rs, 1'b0);
    chk("abort_bb",    o_bb, 1'b0);
    chk("abort_valid", o_vld, 1'b0);
    chk("abort_data",  o_dat, 8'h00);
    reset = 1'b1;
    tick();
    chk("abort_ready", o_rdy, 1'b1);
    extra = 0;
    repeat (100) begin
      tick();
      if (o_vld === 1'b1) extra++;
    end
    chk("abort_no_valid", extra, 0);
    chk("abort_data_kept", o_dat, 8'h00);

    // Short-timing instance: latency 1+6+2+4+1
    sel = 1'b1;
    do_read("short", RS_DATA, 4'h6, 4'h9, 14, 3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
